// File: rtl/i_type_pkg.sv
// Shared RV32I OP-IMM definitions: opcode, funct3/funct7 encodings and
// immediate sign extension used by the execute unit.
package i_type_pkg;

  localparam int          XLEN         = 32;
  localparam logic [6:0]  OPCODE_OPIMM = 7'b0010011;
  localparam logic [6:0]  F7_SRA       = 7'h20;

  typedef enum logic [2:0] {
    F3_ADD  = 3'd0,
    F3_SLL  = 3'd1,
    F3_SLT  = 3'd2,
    F3_SLTU = 3'd3,
    F3_XOR  = 3'd4,
    F3_SR   = 3'd5,
    F3_OR   = 3'd6,
    F3_AND  = 3'd7
  } funct3_e;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

// File: rtl/i_type_opimm_alu.sv
// Combinational OP-IMM datapath and legality decode. Illegal encodings
// drive out to all-X so downstream misuse is visible in simulation.
module opimm_alu
  import i_type_pkg::*;
#(
  parameter int         XLEN   = 32,
  parameter logic [6:0] OPCODE = OPCODE_OPIMM
) (
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [11:0]     imm,
  input  logic [XLEN-1:0] in1,
  output logic [XLEN-1:0] out,
  output logic            illegal
);

  logic [XLEN-1:0] simm;
  logic [4:0]      shamt;
  logic [6:0]      f7;
  logic [XLEN-1:0] result;
  logic            bad;

  assign simm  = sext12(imm);
  assign shamt = imm[4:0];
  assign f7    = imm[11:5];

  always_comb begin
    result = '0;
    bad    = 1'b0;
    case (funct3_e'(funct3))
      F3_ADD:  result = in1 + simm;
      F3_SLL: begin
        bad    = (f7 != 7'd0);
        result = in1 << shamt;
      end
      F3_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(simm))};
      F3_SLTU: result = {{(XLEN-1){1'b0}}, (in1 < simm)};
      F3_XOR:  result = in1 ^ simm;
      F3_SR: begin
        // f7 selects logical vs arithmetic; any other f7 is reserved.
        if (f7 == 7'd0)
          result = in1 >> shamt;
        else if (f7 == F7_SRA)
          result = $signed(in1) >>> shamt;
        else
          bad = 1'b1;
      end
      F3_OR:   result = in1 | simm;
      F3_AND:  result = in1 & simm;
    endcase
    if (opcode != OPCODE)
      bad = 1'b1;
    illegal = bad;
    out     = bad ? 'x : result;
  end

endmodule

// File: rtl/i_type.sv
// OP-IMM execute unit: combinational ALU result plus a registered copy
// and valid flag for the writeback stage.
module i_type
  import i_type_pkg::*;
#(
  parameter int         XLEN         = 32,
  parameter logic [6:0] OPCODE_OPIMM = i_type_pkg::OPCODE_OPIMM
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [11:0]     imm,
  input  logic [XLEN-1:0] in1,
  output logic [XLEN-1:0] out,
  output logic            illegal,
  output logic [XLEN-1:0] out_q,
  output logic            valid_q
);

  opimm_alu #(
    .XLEN   (XLEN),
    .OPCODE (OPCODE_OPIMM)
  ) u_alu (
    .opcode  (opcode),
    .funct3  (funct3),
    .imm     (imm),
    .in1     (in1),
    .out     (out),
    .illegal (illegal)
  );

  // valid_q high: out_q holds the legal result sampled at the last edge.
  // There is no ready/backpressure; writeback consumes every cycle.
  // Illegal cycles store zero so the register never captures X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= ~illegal;
      out_q   <= illegal ? '0 : out;
    end
  end

endmodule

// File: tb/tb_i_type.sv
// Bench for i_type: table-driven vectors, randomized checks against a
// reference model, and a scoreboard queue for the registered stage.
module tb_i_type;

  localparam logic [6:0] OPI = 7'b0010011;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [11:0] imm;
  logic [31:0] in1;
  logic [31:0] out;
  logic        illegal;
  logic [31:0] out_q;
  logic        valid_q;

  i_type dut (
    .clk     (clk),
    .rst     (rst),
    .opcode  (opcode),
    .funct3  (funct3),
    .imm     (imm),
    .in1     (in1),
    .out     (out),
    .illegal (illegal),
    .out_q   (out_q),
    .valid_q (valid_q)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [11:0] imm;
    logic [31:0] in1;
    logic [31:0] exp_out;
    logic        exp_ill;
  } vec_t;

  vec_t        vecs[24];
  logic [32:0] exp_q[$];   // {valid_q, out_q}
  int          n_compared;
  int          n_mismatched;
  logic        xprobe;
  bit          four_state;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // independent reference model: returns {illegal, out}
  function automatic logic [32:0] ref_model(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [11:0] im, input logic [31:0] a);
    logic [31:0] s;
    logic [31:0] r;
    logic        ill;
    int          sh;
    s   = {{20{im[11]}}, im};
    sh  = int'(im[4:0]);
    r   = 32'd0;
    ill = (op != OPI);
    case (f3)
      3'd0: r = a + s;
      3'd1: begin ill = ill | (im[11:5] != 7'd0); r = a << sh; end
      3'd2: r = ($signed(a) < $signed(s)) ? 32'd1 : 32'd0;
      3'd3: r = (a < s) ? 32'd1 : 32'd0;
      3'd4: r = a ^ s;
      3'd5: begin
        if (im[11:5] == 7'd0) r = a >> sh;
        else if (im[11:5] == 7'h20)
          r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
        else ill = 1'b1;
      end
      3'd6: r = a | s;
      default: r = a & s;
    endcase
    return {ill, r};
  endfunction

  task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                       input logic [11:0] im, input logic [31:0] a);
    opcode = op;
    funct3 = f3;
    imm    = im;
    in1    = a;
  endtask

  // drive at negedge, check combinational result, queue registered expectation,
  // then pop and compare after the next rising edge
  task automatic apply(input string name, input logic [6:0] op, input logic [2:0] f3,
                       input logic [11:0] im, input logic [31:0] a,
                       input logic [31:0] e_out, input logic e_ill);
    logic [32:0] e;
    @(negedge clk);
    drive(op, f3, im, a);
    #1;
    check1({name, ".illegal"}, illegal, e_ill);
    if (!e_ill) check32({name, ".out"}, out, e_out);
    else if (four_state) check1({name, ".out_x"}, $isunknown(out), 1'b1);
    exp_q.push_back({~e_ill, e_ill ? 32'd0 : e_out});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL %s.scoreboard: queue empty, expected one entry", name);
    end else begin
      e = exp_q.pop_front();
      check1({name, ".valid_q"}, valid_q, e[32]);
      check32({name, ".out_q"}, out_q, e[31:0]);
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    xprobe       = 1'bx;
    four_state   = $isunknown(xprobe);

    vecs[0]  = '{"addi",        OPI, 3'd0, 12'hFFF, 32'h0000_0010, 32'h0000_000F, 1'b0};
    vecs[1]  = '{"xori",        OPI, 3'd4, 12'h800, 32'h1234_5678, 32'hEDCB_AE78, 1'b0};
    vecs[2]  = '{"ori",         OPI, 3'd6, 12'h0F0, 32'h0000_0000, 32'h0000_00F0, 1'b0};
    vecs[3]  = '{"andi",        OPI, 3'd7, 12'h7FF, 32'hFFFF_FFFF, 32'h0000_07FF, 1'b0};
    vecs[4]  = '{"slli4",       OPI, 3'd1, 12'h004, 32'h8000_0010, 32'h0000_0100, 1'b0};
    vecs[5]  = '{"srli4",       OPI, 3'd5, 12'h004, 32'h8000_0010, 32'h0800_0001, 1'b0};
    vecs[6]  = '{"srai4",       OPI, 3'd5, 12'h404, 32'h8000_0010, 32'hF800_0001, 1'b0};
    vecs[7]  = '{"slli0",       OPI, 3'd1, 12'h000, 32'h8000_0010, 32'h8000_0010, 1'b0};
    vecs[8]  = '{"srli0",       OPI, 3'd5, 12'h000, 32'h8000_0010, 32'h8000_0010, 1'b0};
    vecs[9]  = '{"srai0",       OPI, 3'd5, 12'h400, 32'h8000_0010, 32'h8000_0010, 1'b0};
    vecs[10] = '{"slli31",      OPI, 3'd1, 12'h01F, 32'h0000_0001, 32'h8000_0000, 1'b0};
    vecs[11] = '{"srli31",      OPI, 3'd5, 12'h01F, 32'h8000_0000, 32'h0000_0001, 1'b0};
    vecs[12] = '{"srai31",      OPI, 3'd5, 12'h41F, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0};
    vecs[13] = '{"slti_neg",    OPI, 3'd2, 12'hFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[14] = '{"sltiu_big",   OPI, 3'd3, 12'hFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[15] = '{"sltiu_sext",  OPI, 3'd3, 12'h800, 32'h0000_0005, 32'h0000_0001, 1'b0};
    vecs[16] = '{"slti_min",    OPI, 3'd2, 12'h800, 32'h0000_0005, 32'h0000_0000, 1'b0};
    vecs[17] = '{"sltiu_eq",    OPI, 3'd3, 12'h005, 32'h0000_0005, 32'h0000_0000, 1'b0};
    vecs[18] = '{"addi_wrap",   OPI, 3'd0, 12'h001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[19] = '{"ill_opcode",  7'b0000000, 3'd0, 12'h001, 32'h0000_0001, 32'h0, 1'b1};
    vecs[20] = '{"ill_slli",    OPI, 3'd1, 12'h404, 32'h8000_0010, 32'h0, 1'b1};
    vecs[21] = '{"ill_sr_f7",   OPI, 3'd5, 12'h604, 32'h8000_0010, 32'h0, 1'b1};
    vecs[22] = '{"ill_op_reg",  7'b0110011, 3'd7, 12'h0FF, 32'h1234_5678, 32'h0, 1'b1};
    vecs[23] = '{"addi_after",  OPI, 3'd0, 12'h123, 32'h0000_1000, 32'h0000_1123, 1'b0};

    // async reset visible without any clock edge
    rst = 1'b1;
    drive(OPI, 3'd0, 12'h001, 32'h0000_0001);
    #2;
    check32("reset.out_q", out_q, 32'd0);
    check1("reset.valid_q", valid_q, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      apply(vecs[i].name, vecs[i].opcode, vecs[i].funct3, vecs[i].imm,
            vecs[i].in1, vecs[i].exp_out, vecs[i].exp_ill);

    // randomized stimulus against the reference model
    for (int k = 0; k < 60; k++) begin
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [11:0] im;
      logic [31:0] a;
      logic [32:0] m;
      op = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : OPI;
      f3 = 3'($urandom_range(0, 7));
      im = 12'($urandom_range(0, 4095));
      if (f3 == 3'd1 && $urandom_range(0, 3) != 0) im[11:5] = 7'd0;
      if (f3 == 3'd5 && $urandom_range(0, 3) != 0) im[11:5] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      a  = $urandom;
      m  = ref_model(op, f3, im, a);
      apply("random", op, f3, im, a, m[31:0], m[32]);
    end

    // reset mid-cycle after a legal result: registers clear without an edge,
    // combinational out is untouched
    apply("pre_reset", OPI, 3'd0, 12'h00F, 32'h0000_0100, 32'h0000_010F, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check32("midrst.out_q", out_q, 32'd0);
    check1("midrst.valid_q", valid_q, 1'b0);
    check32("midrst.out", out, 32'h0000_010F);
    check1("midrst.illegal", illegal, 1'b0);
    @(posedge clk);
    #1;
    check1("rst_held.valid_q", valid_q, 1'b0);

    // first edge after release captures the current inputs
    @(negedge clk);
    drive(OPI, 3'd6, 12'h00A, 32'h0000_0500);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check32("post_rst.out_q", out_q, 32'h0000_050A);
    check1("post_rst.valid_q", valid_q, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/i_type.md
Name: i_type

Overview:
- RV32I OP-IMM (opcode 7'b0010011) execute unit.
- Takes the decoded opcode, funct3, 12-bit immediate and rs1 value.
- Produces the ALU result combinationally on out, plus a registered copy with a legal flag for the pipeline's writeback stage.
- Sits between decode and writeback in the integer datapath.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- OPCODE_OPIMM, 7'b0010011, opcode value this unit accepts.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- opcode  input  7  instruction opcode field.
- funct3  input  3  instruction funct3 field.
- imm  input  12  I-type immediate, instr[31:20].
- in1  input  32  rs1 operand.
- out  output  32  combinational result, zero latency.
- illegal  output  1  combinational: 1 when opcode/funct3/imm do not form a legal OP-IMM instruction.
- out_q  output  32  out registered on clk.
- valid_q  output  1  registered ~illegal.

Behaviour:
- simm = sign-extend(imm) to 32 bits; shamt = imm[4:0]; f7 = imm[11:5].
- funct3 0 ADDI: out = in1 + simm, modulo 2^32, no overflow flag.
- funct3 4 XORI: out = in1 ^ simm.
- funct3 6 ORI: out = in1 | simm.
- funct3 7 ANDI: out = in1 & simm.
- funct3 1 SLLI, requires f7 = 0: out = in1 << shamt.
- funct3 5, f7 = 0, SRLI: out = in1 >> shamt, logical, zero fill.
- funct3 5, f7 = 7'h20, SRAI: out = in1 shifted right arithmetically by shamt, replicating in1[31].
- funct3 2 SLTI: out = 1 if signed(in1) < signed(simm), else 0.
- funct3 3 SLTIU: out = 1 if unsigned(in1) < unsigned(simm), else 0. The immediate is sign-extended first, then compared unsigned (RV32I rule), so imm = 12'hFFF compares against 32'hFFFF_FFFF.
- Illegal cases:
  - opcode != OPCODE_OPIMM.
  - funct3 1 with f7 != 0.
  - funct3 5 with f7 not in {0, 7'h20}.
  - In every illegal case: out = 32'hx (all bits unknown) and illegal = 1.
  - Verification checks for X; do not tie illegal results to 0.
- Any legal case: illegal = 0 and out fully known.
- Combinational path has no dependency on clk or rst.
- Register stage:
  - Async reset (rst high): out_q = 0, valid_q = 0, immediately, independent of clk.
  - Each rising clk with rst low: valid_q <= ~illegal.
  - out_q <= out when legal; on an illegal cycle out_q <= 0, so registered state never holds X.
  - rst asserted mid-stream clears both registers at once.
  - First edge after rst deasserts captures the current inputs.
- Shift amount 0 passes in1 unchanged for all three shifts. Shift amount 31 is supported.

Decomposition:
- Shared package (e.g. rv32i_pkg) holds:
  - OPCODE_OPIMM.
  - funct3 enum: F3_ADD = 0, F3_SLL = 1, F3_SLT = 2, F3_SLTU = 3, F3_XOR = 4, F3_SR = 5, F3_OR = 6, F3_AND = 7.
  - F7_SRA = 7'h20.
  - Function sext12 (12 to 32-bit sign extension).
- One natural sub-module: opimm_alu, the pure combinational datapath plus illegal decode. i_type wraps it with the output register.

Test Plan:
- ADDI: in1 = 32'h0000_0010, imm = 12'hFFF -> out = 32'h0000_000F, illegal = 0; next clk edge -> out_q = 32'h0000_000F, valid_q = 1.
- Logic ops:
  - XORI, in1 = 32'h1234_5678, imm = 12'h800 -> out = 32'hEDCB_AE78.
  - ORI, in1 = 0, imm = 12'h0F0 -> 32'h0000_00F0.
  - ANDI, in1 = 32'hFFFF_FFFF, imm = 12'h7FF -> 32'h0000_07FF.
- Shifts, in1 = 32'h8000_0010:
  - SLLI shamt 4 -> 32'h0000_0100.
  - SRLI shamt 4 -> 32'h0800_0001.
  - SRAI (imm = 12'h404) -> 32'hF800_0001.
  - shamt 0 -> 32'h8000_0010.
- Compares:
  - SLTI, in1 = 32'hFFFF_FFFE, imm = 12'hFFF -> 1.
  - SLTIU, same operands -> 1.
  - SLTIU, in1 = 32'h0000_0005, imm = 12'h800 -> 1.
  - SLTI, in1 = 5, imm = 12'h800 -> 0.
- Illegal:
  - opcode = 7'b0000000 -> out all X, illegal = 1; next edge -> out_q = 0, valid_q = 0.
  - SLLI with imm = 12'h404 -> out all X, illegal = 1.
- Reset: load a legal result, then assert rst between edges -> out_q = 0 and valid_q = 0 with no clk edge. Combinational out is unaffected by rst.
